// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage of the pipeline. Issues data-memory requests for
// loads/stores, freezes the upstream pipeline while an access is outstanding,
// formats store data / byte enables, extracts and extends load data, and
// registers the writeback values.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   : misaligned half/word accesses are suppressed (no request, WB
//               bubble) and flagged on the sticky o_addr_err output.
//   undefined : no alignment check; halves use a[1], words ignore a[1:0],
//               o_addr_err is tied low.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no access outstanding; a new memop is requested combinationally
// WAIT   | request issued, holding o_dm_* until i_dm_ack

module mem_access_unit #(
    parameter int NBITS = 32,
    parameter int RBITS = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [NBITS-1:0] MEM_result,
    input  logic [NBITS-1:0] MEM_Rt,
    input  logic [RBITS-1:0] MEM_rd,
    input  logic [4:0]       MEM_sizecontrol,
    input  logic             MEM_memtoreg,
    input  logic             MEM_memread,
    input  logic             MEM_regwrite,
    input  logic             MEM_memwrite,
    input  logic             MEM_haltflag,
    output logic             o_dm_req,
    output logic             o_dm_we,
    output logic [NBITS-1:0] o_dm_addr,
    output logic [NBITS-1:0] o_dm_wdata,
    output logic [3:0]       o_dm_be,
    input  logic             i_dm_ack,
    input  logic [NBITS-1:0] i_dm_rdata,
    output logic             o_stall,
    output logic [NBITS-1:0] WB_data,
    output logic [RBITS-1:0] WB_rd,
    output logic             WB_regwrite,
    output logic             WB_haltflag,
    output logic             o_addr_err
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t state_q, state_d;

    logic [1:0]       a;
    logic             is_byte, is_half, is_word, zext, memop, misaligned;
    logic [4:0]       shamt;
    logic [NBITS-1:0] rshift, load_val;
    logic [NBITS-1:0] wb_data_d;
    logic [RBITS-1:0] wb_rd_d;
    logic             wb_regwrite_d, wb_haltflag_d;
    logic             unused_size_bits;

    assign a       = MEM_result[1:0];
    assign is_byte = (MEM_sizecontrol[1:0] == 2'b00);
    assign is_half = (MEM_sizecontrol[1:0] == 2'b01);
    assign is_word = MEM_sizecontrol[1];
    assign zext    = MEM_sizecontrol[2];
    assign memop   = MEM_memread | MEM_memwrite;
    assign unused_size_bits = ^MEM_sizecontrol[4:3];

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = memop & ((is_half & a[0]) | (is_word & (a != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    // Lane selection: byte enables, replicated store data, load shift amount
    always_comb begin
        o_dm_be    = 4'b1111;
        o_dm_wdata = MEM_Rt;
        shamt      = 5'd0;
        if (is_byte) begin
            o_dm_be    = 4'b0001 << a;
            o_dm_wdata = {4{MEM_Rt[7:0]}};
            shamt      = {a, 3'b000};
        end else if (is_half) begin
            o_dm_be    = 4'b0011 << {a[1], 1'b0};
            o_dm_wdata = {2{MEM_Rt[15:0]}};
            shamt      = {a[1], 4'b0000};
        end
    end

    assign o_dm_addr = {MEM_result[NBITS-1:2], 2'b00};
    assign rshift    = i_dm_rdata >> shamt;

    // Load extension from 8/16/32 bits
    always_comb begin
        load_val = rshift;
        if (is_byte)
            load_val = {{(NBITS-8){~zext & rshift[7]}}, rshift[7:0]};
        else if (is_half)
            load_val = {{(NBITS-16){~zext & rshift[15]}}, rshift[15:0]};
    end

    // Request FSM: next state and request strobe
    always_comb begin
        state_d  = state_q;
        o_dm_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (memop && !misaligned) begin
                    o_dm_req = 1'b1;
                    if (!i_dm_ack) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                o_dm_req = 1'b1;
                if (i_dm_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_dm_we = o_dm_req & MEM_memwrite;
    assign o_stall = o_dm_req & ~i_dm_ack;

    // Writeback next values: bubble while stalled or on a suppressed access
    always_comb begin
        wb_data_d     = WB_data;
        wb_rd_d       = WB_rd;
        wb_regwrite_d = 1'b0;
        wb_haltflag_d = 1'b0;
        if (!o_stall && !misaligned) begin
            wb_data_d     = MEM_memtoreg ? load_val : MEM_result;
            wb_rd_d       = MEM_rd;
            wb_regwrite_d = MEM_regwrite;
            wb_haltflag_d = MEM_haltflag;
        end
    end

    // State and writeback registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            WB_data     <= '0;
            WB_rd       <= '0;
            WB_regwrite <= 1'b0;
            WB_haltflag <= 1'b0;
        end else begin
            state_q     <= state_d;
            WB_data     <= wb_data_d;
            WB_rd       <= wb_rd_d;
            WB_regwrite <= wb_regwrite_d;
            WB_haltflag <= wb_haltflag_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic addr_err_q;

    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) addr_err_q <= 1'b0;
        else       addr_err_q <= addr_err_q | misaligned;
    end

    assign o_addr_err = addr_err_q;
`else
    assign o_addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        i_clk, i_rst;
    logic [31:0] MEM_result, MEM_Rt;
    logic [4:0]  MEM_rd, MEM_sizecontrol;
    logic        MEM_memtoreg, MEM_memread, MEM_regwrite, MEM_memwrite, MEM_haltflag;
    logic        o_dm_req, o_dm_we;
    logic [31:0] o_dm_addr, o_dm_wdata;
    logic [3:0]  o_dm_be;
    logic        i_dm_ack;
    logic [31:0] i_dm_rdata;
    logic        o_stall;
    logic [31:0] WB_data;
    logic [4:0]  WB_rd;
    logic        WB_regwrite, WB_haltflag, o_addr_err;

    int total = 0;
    int bad   = 0;

    mem_access_unit #(.NBITS(32), .RBITS(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .MEM_result(MEM_result), .MEM_Rt(MEM_Rt), .MEM_rd(MEM_rd),
        .MEM_sizecontrol(MEM_sizecontrol), .MEM_memtoreg(MEM_memtoreg),
        .MEM_memread(MEM_memread), .MEM_regwrite(MEM_regwrite),
        .MEM_memwrite(MEM_memwrite), .MEM_haltflag(MEM_haltflag),
        .o_dm_req(o_dm_req), .o_dm_we(o_dm_we), .o_dm_addr(o_dm_addr),
        .o_dm_wdata(o_dm_wdata), .o_dm_be(o_dm_be), .i_dm_ack(i_dm_ack),
        .i_dm_rdata(i_dm_rdata), .o_stall(o_stall), .WB_data(WB_data),
        .WB_rd(WB_rd), .WB_regwrite(WB_regwrite), .WB_haltflag(WB_haltflag),
        .o_addr_err(o_addr_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] result, rt;
        logic [4:0]  rd, size;
        logic        mtr, mrd, rw, mwr, halt, ack;
        logic [31:0] rdata;
        logic        e_req, e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic [31:0] e_wb;
        logic [4:0]  e_rd;
        logic        e_rw, e_halt;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        MEM_result = 0; MEM_Rt = 0; MEM_rd = 0; MEM_sizecontrol = 5'd2;
        MEM_memtoreg = 0; MEM_memread = 0; MEM_regwrite = 0;
        MEM_memwrite = 0; MEM_haltflag = 0; i_dm_ack = 0; i_dm_rdata = 0;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [4:0] rd, input logic ack);
        MEM_result = addr; MEM_Rt = 0; MEM_rd = rd; MEM_sizecontrol = 5'd2;
        MEM_memtoreg = 1; MEM_memread = 1; MEM_regwrite = 1;
        MEM_memwrite = 0; MEM_haltflag = 0; i_dm_ack = ack;
    endtask

    initial begin
        // order: result, rt, rd, size, mtr, mrd, rw, mwr, halt, ack, rdata |
        //        req, we, addr, be, wdata, stall, wb_data, wb_rd, wb_rw, wb_halt
        vecs[0]  = '{32'h55, 32'h0, 5'd7, 5'd2, 0,0,1,0,0,1, 32'h0,
                     0,0, 32'h54, 4'hF, 32'h0, 0, 32'h55, 5'd7, 1,0};
        vecs[1]  = '{32'h13, 32'h0, 5'd3, 5'd0, 1,1,1,0,0,1, 32'h80FFFF7F,
                     1,0, 32'h10, 4'h8, 32'h0, 0, 32'hFFFFFF80, 5'd3, 1,0};
        vecs[2]  = '{32'h13, 32'h0, 5'd3, 5'd4, 1,1,1,0,0,1, 32'h80FFFF7F,
                     1,0, 32'h10, 4'h8, 32'h0, 0, 32'h00000080, 5'd3, 1,0};
        vecs[3]  = '{32'h22, 32'h1234ABCD, 5'd0, 5'd1, 0,0,0,1,0,1, 32'h0,
                     1,1, 32'h20, 4'hC, 32'hABCDABCD, 0, 32'h22, 5'd0, 0,0};
        vecs[4]  = '{32'h12, 32'h0, 5'd5, 5'd1, 1,1,1,0,0,1, 32'h80017FFF,
                     1,0, 32'h10, 4'hC, 32'h0, 0, 32'hFFFF8001, 5'd5, 1,0};
        vecs[5]  = '{32'h20, 32'h0, 5'd6, 5'd2, 1,1,1,0,0,1, 32'h12345678,
                     1,0, 32'h20, 4'hF, 32'h0, 0, 32'h12345678, 5'd6, 1,0};
        vecs[6]  = '{32'h24, 32'h0, 5'd8, 5'h1B, 1,1,1,0,0,1, 32'hCAFEF00D,
                     1,0, 32'h24, 4'hF, 32'h0, 0, 32'hCAFEF00D, 5'd8, 1,0};
        vecs[7]  = '{32'h11, 32'h0, 5'd9, 5'd4, 1,1,1,0,0,1, 32'h0000AB00,
                     1,0, 32'h10, 4'h2, 32'h0, 0, 32'h000000AB, 5'd9, 1,0};
        vecs[8]  = '{32'h12, 32'hEE, 5'd0, 5'd0, 0,0,0,1,0,1, 32'h0,
                     1,1, 32'h10, 4'h4, 32'hEEEEEEEE, 0, 32'h12, 5'd0, 0,0};
        vecs[9]  = '{32'h0, 32'h0, 5'd0, 5'd2, 0,0,0,0,1,0, 32'h0,
                     0,0, 32'h0, 4'hF, 32'h0, 0, 32'h0, 5'd0, 0,1};
        vecs[10] = '{32'h30, 32'h11112222, 5'd0, 5'd2, 0,1,0,1,0,1, 32'h0,
                     1,1, 32'h30, 4'hF, 32'h11112222, 0, 32'h30, 5'd0, 0,0};

        // Reset
        drive_idle();
        i_rst = 1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk); #1;
        chk("rst_wb_data", WB_data, 0);
        chk("rst_wb_rd", 32'(WB_rd), 0);
        chk("rst_wb_rw", 32'(WB_regwrite), 0);
        chk("rst_wb_halt", 32'(WB_haltflag), 0);
        chk("rst_addr_err", 32'(o_addr_err), 0);
        chk("rst_req", 32'(o_dm_req), 0);
        i_rst = 0;

        // Single-cycle vectors
        for (int i = 0; i < 11; i++) begin
            @(negedge i_clk);
            MEM_result = vecs[i].result; MEM_Rt = vecs[i].rt; MEM_rd = vecs[i].rd;
            MEM_sizecontrol = vecs[i].size; MEM_memtoreg = vecs[i].mtr;
            MEM_memread = vecs[i].mrd; MEM_regwrite = vecs[i].rw;
            MEM_memwrite = vecs[i].mwr; MEM_haltflag = vecs[i].halt;
            i_dm_ack = vecs[i].ack; i_dm_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i), 32'(o_dm_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_we", i), 32'(o_dm_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_addr", i), o_dm_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_be", i), 32'(o_dm_be), 32'(vecs[i].e_be));
            if (vecs[i].e_req)
                chk($sformatf("v%0d_wdata", i), o_dm_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_stall", i), 32'(o_stall), 32'(vecs[i].e_stall));
            @(posedge i_clk); #1;
            chk($sformatf("v%0d_wb_data", i), WB_data, vecs[i].e_wb);
            chk($sformatf("v%0d_wb_rd", i), 32'(WB_rd), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_wb_rw", i), 32'(WB_regwrite), 32'(vecs[i].e_rw));
            chk($sformatf("v%0d_wb_halt", i), 32'(WB_haltflag), 32'(vecs[i].e_halt));
            chk($sformatf("v%0d_addr_err", i), 32'(o_addr_err), 0);
        end

        // Word load with ack three cycles after the request
        @(negedge i_clk);
        drive_load(32'h10, 5'd9, 1'b0);
        i_dm_rdata = 32'h0BAD0BAD;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("w%0d_req", c), 32'(o_dm_req), 1);
            chk($sformatf("w%0d_stall", c), 32'(o_stall), 1);
            chk($sformatf("w%0d_addr", c), o_dm_addr, 32'h10);
            chk($sformatf("w%0d_be", c), 32'(o_dm_be), 32'hF);
            @(posedge i_clk); #1;
            chk($sformatf("w%0d_bubble_rw", c), 32'(WB_regwrite), 0);
            chk($sformatf("w%0d_hold_data", c), WB_data, 32'h30);
            @(negedge i_clk);
        end
        i_dm_ack = 1; i_dm_rdata = 32'hDEADBEEF;
        #1;
        chk("w_ack_req", 32'(o_dm_req), 1);
        chk("w_ack_stall", 32'(o_stall), 0);
        @(posedge i_clk); #1;
        chk("w_wb_data", WB_data, 32'hDEADBEEF);
        chk("w_wb_rw", 32'(WB_regwrite), 1);
        chk("w_wb_rd", 32'(WB_rd), 9);
        @(negedge i_clk);
        drive_idle();
        #1;
        chk("w_after_req", 32'(o_dm_req), 0);

        // Misaligned word load at 0x102
        @(negedge i_clk);
        drive_load(32'h102, 5'd4, 1'b0);
        i_dm_rdata = 32'hA5A5A5A5;
`ifdef MEM_ALIGN_CHECK_EN
        #1;
        chk("mis_req", 32'(o_dm_req), 0);
        chk("mis_stall", 32'(o_stall), 0);
        @(posedge i_clk); #1;
        chk("mis_err", 32'(o_addr_err), 1);
        chk("mis_wb_rw", 32'(WB_regwrite), 0);
        @(negedge i_clk);
        drive_idle();
        @(posedge i_clk); #1;
        chk("mis_err_sticky", 32'(o_addr_err), 1);
`else
        i_dm_ack = 1;
        #1;
        chk("mis_req", 32'(o_dm_req), 1);
        chk("mis_addr", o_dm_addr, 32'h100);
        @(posedge i_clk); #1;
        chk("mis_wb_data", WB_data, 32'hA5A5A5A5);
        chk("mis_err", 32'(o_addr_err), 0);
`endif

        // Reset while waiting, then a late ack
        @(negedge i_clk);
        drive_load(32'h10, 5'd3, 1'b0);
        @(negedge i_clk);
        i_rst = 1;
        @(negedge i_clk);
        i_rst = 0;
        drive_idle();
        i_dm_ack = 1; i_dm_rdata = 32'hFFFFFFFF;
        #1;
        chk("ra_req", 32'(o_dm_req), 0);
        chk("ra_stall", 32'(o_stall), 0);
        chk("ra_wb_data", WB_data, 0);
        chk("ra_wb_rd", 32'(WB_rd), 0);
        chk("ra_wb_rw", 32'(WB_regwrite), 0);
        chk("ra_wb_halt", 32'(WB_haltflag), 0);
        chk("ra_addr_err", 32'(o_addr_err), 0);
        @(negedge i_clk);
        drive_load(32'h40, 5'd2, 1'b0);
        #1;
        chk("ra_new_req", 32'(o_dm_req), 1);
        chk("ra_new_stall", 32'(o_stall), 1);
        i_dm_ack = 1; i_dm_rdata = 32'h600DF00D;
        @(posedge i_clk); #1;
        chk("ra_new_wb", WB_data, 32'h600DF00D);
        @(negedge i_clk);
        drive_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
